// File: rtl/mem_access_stage.sv
// Memory stage of the MIPS pipeline. Takes the ALU result from EX, runs the
// req/ack handshake to data memory for LW/SW, and presents registered results
// to writeback. Misaligned LW/SW and memory timeouts are flagged as
// single-cycle exception pulses alongside a wb_valid with reg write disabled.
//
// state  | meaning
// IDLE   | ready for a new instruction from EX
// ACCESS | memory request outstanding, EX stalled

`ifndef OPCODE_LW
`define OPCODE_LW 6'h23
`endif
`ifndef OPCODE_SW
`define OPCODE_SW 6'h2b
`endif

module mem_access_stage #(
  parameter int TIMEOUT_CYCLES = 16
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        ex_valid,
  output logic        ex_ready,
  input  logic [5:0]  ex_opcode,
  input  logic [31:0] ex_alu_out,
  input  logic [31:0] ex_store_data,
  input  logic [4:0]  ex_dest,
  input  logic        ex_reg_write,
  output logic        mem_req,
  output logic        mem_we,
  output logic [31:0] mem_addr,
  output logic [31:0] mem_wdata,
  input  logic [31:0] mem_rdata,
  input  logic        mem_ack,
  output logic        wb_valid,
  output logic [31:0] wb_data,
  output logic [4:0]  wb_dest,
  output logic        wb_reg_write,
  output logic        exc_misalign,
  output logic        exc_bus_err
);

  typedef enum logic {
    IDLE   = 1'b0,
    ACCESS = 1'b1
  } state_t;

  // Last counter value before the access is declared dead.
  localparam logic [7:0] CNT_LAST = 8'(TIMEOUT_CYCLES - 1);

  state_t      state_q, state_d;
  logic [7:0]  cnt_q, cnt_d;
  logic        mem_req_q, mem_req_d;
  logic        mem_we_q, mem_we_d;
  logic [31:0] mem_addr_q, mem_addr_d;
  logic [31:0] mem_wdata_q, mem_wdata_d;
  logic [4:0]  dest_q, dest_d;
  logic        reg_write_q, reg_write_d;
  logic        wb_valid_q, wb_valid_d;
  logic [31:0] wb_data_q, wb_data_d;
  logic [4:0]  wb_dest_q, wb_dest_d;
  logic        wb_reg_write_q, wb_reg_write_d;
  logic        exc_misalign_q, exc_misalign_d;
  logic        exc_bus_err_q, exc_bus_err_d;

  logic is_lw, is_sw, is_mem;

  assign is_lw  = (ex_opcode == `OPCODE_LW);
  assign is_sw  = (ex_opcode == `OPCODE_SW);
  assign is_mem = is_lw | is_sw;

  // Next-state and next-output logic; pulses default low every cycle.
  always_comb begin
    state_d        = state_q;
    cnt_d          = cnt_q;
    mem_req_d      = mem_req_q;
    mem_we_d       = mem_we_q;
    mem_addr_d     = mem_addr_q;
    mem_wdata_d    = mem_wdata_q;
    dest_d         = dest_q;
    reg_write_d    = reg_write_q;
    wb_valid_d     = 1'b0;
    wb_data_d      = wb_data_q;
    wb_dest_d      = wb_dest_q;
    wb_reg_write_d = 1'b0;
    exc_misalign_d = 1'b0;
    exc_bus_err_d  = 1'b0;

    if (state_q == IDLE) begin
      if (ex_valid) begin
        if (!is_mem) begin
          wb_valid_d     = 1'b1;
          wb_data_d      = ex_alu_out;
          wb_dest_d      = ex_dest;
          wb_reg_write_d = ex_reg_write;
        end else if (ex_alu_out[1:0] != 2'b00) begin
          // Misaligned: report and retire without touching memory.
          exc_misalign_d = 1'b1;
          wb_valid_d     = 1'b1;
          wb_data_d      = 32'h0;
          wb_dest_d      = ex_dest;
        end else begin
          state_d     = ACCESS;
          cnt_d       = 8'd0;
          mem_req_d   = 1'b1;
          mem_we_d    = is_sw;
          mem_addr_d  = {ex_alu_out[31:2], 2'b00};
          mem_wdata_d = ex_store_data;
          dest_d      = ex_dest;
          reg_write_d = ex_reg_write;
        end
      end
    end else begin
      if (mem_ack) begin
        // Ack takes priority over a timeout in the same cycle.
        state_d    = IDLE;
        mem_req_d  = 1'b0;
        wb_valid_d = 1'b1;
        wb_dest_d  = dest_q;
        if (mem_we_q) begin
          wb_data_d = 32'h0;
        end else begin
          wb_data_d      = mem_rdata;
          wb_reg_write_d = reg_write_q;
        end
      end else if (cnt_q == CNT_LAST) begin
        state_d       = IDLE;
        mem_req_d     = 1'b0;
        exc_bus_err_d = 1'b1;
        wb_valid_d    = 1'b1;
        wb_data_d     = 32'h0;
        wb_dest_d     = dest_q;
      end else begin
        cnt_d = cnt_q + 8'd1;
      end
    end
  end

  // State and output registers; reset abandons any outstanding access.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q        <= IDLE;
      cnt_q          <= 8'd0;
      mem_req_q      <= 1'b0;
      mem_we_q       <= 1'b0;
      mem_addr_q     <= 32'h0;
      mem_wdata_q    <= 32'h0;
      dest_q         <= 5'd0;
      reg_write_q    <= 1'b0;
      wb_valid_q     <= 1'b0;
      wb_data_q      <= 32'h0;
      wb_dest_q      <= 5'd0;
      wb_reg_write_q <= 1'b0;
      exc_misalign_q <= 1'b0;
      exc_bus_err_q  <= 1'b0;
    end else begin
      state_q        <= state_d;
      cnt_q          <= cnt_d;
      mem_req_q      <= mem_req_d;
      mem_we_q       <= mem_we_d;
      mem_addr_q     <= mem_addr_d;
      mem_wdata_q    <= mem_wdata_d;
      dest_q         <= dest_d;
      reg_write_q    <= reg_write_d;
      wb_valid_q     <= wb_valid_d;
      wb_data_q      <= wb_data_d;
      wb_dest_q      <= wb_dest_d;
      wb_reg_write_q <= wb_reg_write_d;
      exc_misalign_q <= exc_misalign_d;
      exc_bus_err_q  <= exc_bus_err_d;
    end
  end

  assign ex_ready     = (state_q == IDLE);
  assign mem_req      = mem_req_q;
  assign mem_we       = mem_we_q;
  assign mem_addr     = mem_addr_q;
  assign mem_wdata    = mem_wdata_q;
  assign wb_valid     = wb_valid_q;
  assign wb_data      = wb_data_q;
  assign wb_dest      = wb_dest_q;
  assign wb_reg_write = wb_reg_write_q;
  assign exc_misalign = exc_misalign_q;
  assign exc_bus_err  = exc_bus_err_q;

endmodule

// File: doc/mem_access_stage.md
Name: mem_access_stage

Overview:
- Memory stage of the MIPS pipeline, directly downstream of the ALU/EX stage.
- Consumes the ALU result: it is the effective address for LW/SW and the writeback value for all other instructions.
- Runs the req/ack handshake to data memory, stalls EX while an access is outstanding, and presents registered results to writeback.
- Flags misaligned accesses and memory timeouts.

Parameters:
- TIMEOUT_CYCLES, 16, cycles to wait for mem_ack before aborting with a bus error. Legal range 1..255.

Ports:
- clk  in  1  pipeline clock, rising edge
- rst_n  in  1  asynchronous active-low reset
- ex_valid  in  1  EX presents an instruction this cycle
- ex_ready  out  1  stage can accept; EX holds its outputs while low
- ex_opcode  in  6  instruction opcode, decoded with the shared OPCODE_LW / OPCODE_SW defines
- ex_alu_out  in  32  ALU result: address for LW/SW, value otherwise
- ex_store_data  in  32  rt value for SW
- ex_dest  in  5  destination register
- ex_reg_write  in  1  instruction writes a register
- mem_req  out  1  memory request
- mem_we  out  1  1 = store, 0 = load
- mem_addr  out  32  word address, byte-addressed, bits [1:0] always 0
- mem_wdata  out  32  store data
- mem_rdata  in  32  load data, valid when mem_ack=1
- mem_ack  in  1  one-cycle completion pulse
- wb_valid  out  1  one-cycle pulse: result valid for writeback
- wb_data  out  32  load data or pass-through ALU result
- wb_dest  out  5  destination register
- wb_reg_write  out  1  register write enable, qualified by wb_valid
- exc_misalign  out  1  one-cycle pulse: LW/SW with alu_out[1:0]!=0
- exc_bus_err  out  1  one-cycle pulse: access timed out

Behaviour:
- Reset (async, rst_n=0): state=IDLE; all outputs 0 except ex_ready=1; timeout counter=0. An outstanding access is abandoned and no writeback occurs.
- States: IDLE, ACCESS.
  - ex_ready = (state==IDLE).
  - Accept = ex_valid & ex_ready.
- IDLE, accept of a non-LW/SW instruction:
  - Next edge: wb_valid=1, wb_data=ex_alu_out, wb_dest=ex_dest, wb_reg_write=ex_reg_write.
  - Latency 1 cycle. Back-to-back accepts give one result per cycle.
- IDLE, accept of LW/SW with ex_alu_out[1:0]!=0:
  - Next edge: exc_misalign=1, wb_valid=1, wb_reg_write=0; no memory request.
  - Stays IDLE.
- IDLE, accept of aligned LW/SW:
  - Next edge: state=ACCESS, mem_req=1, mem_we=(SW), mem_addr=ex_alu_out, mem_wdata=ex_store_data.
  - Dest and reg_write are latched; counter cleared.
- ACCESS:
  - mem_req, mem_we, mem_addr and mem_wdata are held stable until completion.
  - The counter increments each cycle that mem_ack=0.
- ACCESS with mem_ack=1 (first cycle of ACCESS included):
  - Next edge: mem_req=0, state=IDLE, wb_valid=1.
  - LW: wb_data=mem_rdata, wb_reg_write=latched value.
  - SW: wb_data=0, wb_reg_write=0.
  - LW minimum latency 2 cycles (accept to wb_valid) with immediate ack.
- ACCESS with counter==TIMEOUT_CYCLES-1 and mem_ack=0:
  - Next edge: mem_req=0, exc_bus_err=1, wb_valid=1, wb_reg_write=0, state=IDLE.
  - Ack and timeout in the same cycle: ack wins.
- mem_ack while in IDLE is ignored.
- wb_valid, exc_misalign and exc_bus_err are single-cycle pulses, cleared on the following edge unless re-asserted.
- The stage never accepts during ACCESS; the instruction after a LW/SW is accepted at the earliest on the edge that returns to IDLE +1 cycle (ex_ready rises with state=IDLE).
- Arithmetic: only the counter (8-bit) is arithmetic; no address modification.

Test Plan:
- Opcode R-type ADDU, ex_alu_out=0x0000_0007, ex_dest=5, reg_write=1 -> next cycle wb_valid=1, wb_data=7, wb_dest=5, wb_reg_write=1, mem_req stays 0.
- LW addr 0x0000_0100, mem_ack pulsed 3 cycles after mem_req with rdata=0xDEAD_BEEF:
  - mem_req and mem_addr stable for 3 cycles, ex_ready=0.
  - Then wb_data=0xDEAD_BEEF, wb_valid=1, ex_ready=1.
- SW addr 0x0000_0204, data 0x1234_5678, immediate ack -> mem_we=1, mem_wdata=0x1234_5678 for 1 cycle; wb_valid=1 with wb_reg_write=0.
- LW addr 0x0000_0102 -> exc_misalign pulse, wb_reg_write=0, mem_req never asserted.
- LW with no ack, TIMEOUT_CYCLES=16 -> mem_req high exactly 16 cycles, then exc_bus_err pulse and return to IDLE.
- rst_n low mid-ACCESS -> mem_req=0 asynchronously; no wb_valid afterwards; a new LW after reset completes normally.
